// File: rtl/vga_timing_pkg.sv
// Shared timing constants and types for the VGA pixel timing generator.
// Defaults describe 640x480@60 with a 25.175 MHz pixel clock.
package vga_timing_pkg;

    // Counter width and the largest total the counters can represent.
    localparam int unsigned COORD_W     = 10;
    localparam int unsigned COORD_LIMIT = 1 << COORD_W;

    // Horizontal timing, in pixels.
    localparam int unsigned DEF_H_VISIBLE = 640;
    localparam int unsigned DEF_H_FP      = 16;
    localparam int unsigned DEF_H_SYNC    = 96;
    localparam int unsigned DEF_H_BP      = 48;

    // Vertical timing, in lines.
    localparam int unsigned DEF_V_VISIBLE = 480;
    localparam int unsigned DEF_V_FP      = 10;
    localparam int unsigned DEF_V_SYNC    = 2;
    localparam int unsigned DEF_V_BP      = 33;

    // Downstream draw path latency (ROM read + colour register).
    localparam int unsigned DEF_PIPE_DELAY = 2;

    // Derived values for the default mode.
    localparam int unsigned H_TOTAL  = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int unsigned V_TOTAL  = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int unsigned HS_START = DEF_H_VISIBLE + DEF_H_FP;
    localparam int unsigned HS_END   = HS_START + DEF_H_SYNC;
    localparam int unsigned VS_START = DEF_V_VISIBLE + DEF_V_FP;
    localparam int unsigned VS_END   = VS_START + DEF_V_SYNC;

    // Raster coordinate.
    typedef logic [COORD_W-1:0] coord_t;

    // One bit wider than a coordinate so bounds equal to COORD_LIMIT still fit.
    typedef logic [COORD_W:0] span_t;

    // Inactive level of {blank, hs, vs}: display disabled, syncs deasserted.
    localparam logic [2:0] SYNC_IDLE = 3'b011;

    // True when lo <= v < hi, compared without truncating the bounds.
    function automatic logic in_span(input coord_t v, input span_t lo, input span_t hi);
        return ({1'b0, v} >= lo) && ({1'b0, v} < hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_sync_delay_pipe.sv
// Clock-enable gated shift register that delays the sync/blank bundle so it
// lines up with the registered colour output of the draw stages.
module sync_delay_pipe #(
    parameter int unsigned      DEPTH = 2,
    parameter int unsigned      WIDTH = 3,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ce,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DEPTH < 1 || DEPTH > 4) begin : g_depth_err
        $error("sync_delay_pipe: DEPTH must be in 1..4");
    end

    logic [WIDTH-1:0] stage [DEPTH];

    // Shift one stage per advanced pixel; reset loads the inactive value everywhere.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage[i] <= INIT;
            end
        end else if (ce) begin
            stage[0] <= din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA pixel timing generator: raster counters, registered display-enable and
// sync decode, plus sync/blank copies delayed to match the draw pipeline.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_VISIBLE  = DEF_H_VISIBLE,
    parameter int unsigned H_FP       = DEF_H_FP,
    parameter int unsigned H_SYNC     = DEF_H_SYNC,
    parameter int unsigned H_BP       = DEF_H_BP,
    parameter int unsigned V_VISIBLE  = DEF_V_VISIBLE,
    parameter int unsigned V_FP       = DEF_V_FP,
    parameter int unsigned V_SYNC     = DEF_V_SYNC,
    parameter int unsigned V_BP       = DEF_V_BP,
    parameter int unsigned PIPE_DELAY = DEF_PIPE_DELAY
) (
    input  logic   vga_clk,
    input  logic   reset_n,
    input  logic   ce,
    output coord_t DrawX,
    output coord_t DrawY,
    output logic   blank,
    output logic   hs,
    output logic   vs,
    output logic   sof,
    output logic   blank_d,
    output logic   hs_d,
    output logic   vs_d
);

    localparam int unsigned H_TOT = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_VISIBLE + V_FP + V_SYNC + V_BP;

    if (H_TOT > COORD_LIMIT || V_TOT > COORD_LIMIT) begin : g_total_err
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end

    if (PIPE_DELAY < 1 || PIPE_DELAY > 4) begin : g_pipe_err
        $error("vga_timing_gen: PIPE_DELAY must be in 1..4");
    end

    // Decode bounds are held one bit wider than a coordinate so a region that
    // ends exactly at 1024 is still represented without wrapping.
    localparam coord_t H_LAST   = coord_t'(H_TOT - 1);
    localparam coord_t V_LAST   = coord_t'(V_TOT - 1);
    localparam span_t  H_VIS_W  = span_t'(H_VISIBLE);
    localparam span_t  V_VIS_W  = span_t'(V_VISIBLE);
    localparam span_t  HS_LO    = span_t'(H_VISIBLE + H_FP);
    localparam span_t  HS_HI    = span_t'(H_VISIBLE + H_FP + H_SYNC);
    localparam span_t  VS_LO    = span_t'(V_VISIBLE + V_FP);
    localparam span_t  VS_HI    = span_t'(V_VISIBLE + V_FP + V_SYNC);

    coord_t next_x;
    coord_t next_y;
    logic   next_blank;
    logic   next_hs;
    logic   next_vs;
    logic   next_sof;

    // Next raster position: wrap the column at end of line, bump or wrap the row with it.
    always_comb begin
        next_x = DrawX;
        next_y = DrawY;
        if (DrawX == H_LAST) begin
            next_x = '0;
            if (DrawY == V_LAST) begin
                next_y = '0;
            end else begin
                next_y = DrawY + coord_t'(1);
            end
        end else begin
            next_x = DrawX + coord_t'(1);
        end
    end

    // Decode from the next position so the registered flags describe the registered counters.
    always_comb begin
        next_blank = ({1'b0, next_x} < H_VIS_W) && ({1'b0, next_y} < V_VIS_W);
        next_hs    = !in_span(next_x, HS_LO, HS_HI);
        next_vs    = !in_span(next_y, VS_LO, VS_HI);
        next_sof   = (next_x == '0) && (next_y == '0);
    end

    // Counters and decoded flags advance together on ce; reset forces the (0,0) state.
    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            DrawX <= '0;
            DrawY <= '0;
            blank <= 1'b1;
            hs    <= 1'b1;
            vs    <= 1'b1;
            sof   <= 1'b1;
        end else if (ce) begin
            DrawX <= next_x;
            DrawY <= next_y;
            blank <= next_blank;
            hs    <= next_hs;
            vs    <= next_vs;
            sof   <= next_sof;
        end
    end

    logic [2:0] sync_now;
    logic [2:0] sync_late;

    assign sync_now = {blank, hs, vs};

    sync_delay_pipe #(
        .DEPTH (PIPE_DELAY),
        .WIDTH (3),
        .INIT  (SYNC_IDLE)
    ) u_sync_delay (
        .clk     (vga_clk),
        .reset_n (reset_n),
        .ce      (ce),
        .din     (sync_now),
        .dout    (sync_late)
    );

    assign {blank_d, hs_d, vs_d} = sync_late;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: a default 640x480 instance and a
// small-raster instance with PIPE_DELAY=3 so whole frames fit in a short run.
module tb_vga_timing_gen;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       b;
        logic       h;
        logic       v;
        logic       s;
        logic       bd;
        logic       hd;
        logic       vd;
    } obs_t;

    // Index 0: default 640x480 mode, index 1: 16x12 raster.
    localparam int HV [2] = '{640, 8};
    localparam int HF [2] = '{16, 2};
    localparam int HSY[2] = '{96, 3};
    localparam int HB [2] = '{48, 3};
    localparam int VV [2] = '{480, 6};
    localparam int VF [2] = '{10, 2};
    localparam int VSY[2] = '{2, 2};
    localparam int VB [2] = '{33, 2};
    localparam int PD [2] = '{2, 3};

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic ce = 1'b0;

    always #5 clk = ~clk;

    logic [9:0] a_x, a_y, s_x, s_y;
    logic a_b, a_h, a_v, a_sof, a_bd, a_hd, a_vd;
    logic s_b, s_h, s_v, s_sof, s_bd, s_hd, s_vd;

    vga_timing_gen dut (
        .vga_clk (clk), .reset_n (reset_n), .ce (ce),
        .DrawX (a_x), .DrawY (a_y), .blank (a_b), .hs (a_h), .vs (a_v), .sof (a_sof),
        .blank_d (a_bd), .hs_d (a_hd), .vs_d (a_vd)
    );

    vga_timing_gen #(
        .H_VISIBLE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_VISIBLE (6), .V_FP (2), .V_SYNC (2), .V_BP (2),
        .PIPE_DELAY (3)
    ) dut_s (
        .vga_clk (clk), .reset_n (reset_n), .ce (ce),
        .DrawX (s_x), .DrawY (s_y), .blank (s_b), .hs (s_h), .vs (s_v), .sof (s_sof),
        .blank_d (s_bd), .hs_d (s_hd), .vs_d (s_vd)
    );

    int nchk = 0;
    int nerr = 0;

    int mx[2];
    int my[2];
    logic [2:0] hist0[$];
    logic [2:0] hist1[$];
    obs_t sb0[$];
    obs_t sb1[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic obs_t model_out(input int id);
        obs_t o;
        int hlo, hhi, vlo, vhi;
        hlo = HV[id] + HF[id];
        hhi = hlo + HSY[id];
        vlo = VV[id] + VF[id];
        vhi = vlo + VSY[id];
        o.x = 10'(mx[id]);
        o.y = 10'(my[id]);
        o.b = (mx[id] < HV[id]) && (my[id] < VV[id]);
        o.h = !((mx[id] >= hlo) && (mx[id] < hhi));
        o.v = !((my[id] >= vlo) && (my[id] < vhi));
        o.s = (mx[id] == 0) && (my[id] == 0);
        {o.bd, o.hd, o.vd} = (id == 0) ? hist0[0] : hist1[0];
        return o;
    endfunction

    // Drive one clock of stimulus, update both models, and score the result.
    task automatic step(input logic rn, input logic c);
        obs_t cur;
        obs_t e;
        obs_t o;
        reset_n = rn;
        ce = c;
        for (int id = 0; id < 2; id++) begin
            if (!rn) begin
                mx[id] = 0;
                my[id] = 0;
                if (id == 0) begin
                    hist0.delete();
                    repeat (PD[0]) hist0.push_back(3'b011);
                end else begin
                    hist1.delete();
                    repeat (PD[1]) hist1.push_back(3'b011);
                end
            end else if (c) begin
                cur = model_out(id);
                if (id == 0) begin
                    void'(hist0.pop_front());
                    hist0.push_back({cur.b, cur.h, cur.v});
                end else begin
                    void'(hist1.pop_front());
                    hist1.push_back({cur.b, cur.h, cur.v});
                end
                if (mx[id] == HV[id] + HF[id] + HSY[id] + HB[id] - 1) begin
                    mx[id] = 0;
                    if (my[id] == VV[id] + VF[id] + VSY[id] + VB[id] - 1) my[id] = 0;
                    else my[id] = my[id] + 1;
                end else begin
                    mx[id] = mx[id] + 1;
                end
            end
        end
        sb0.push_back(model_out(0));
        sb1.push_back(model_out(1));
        @(posedge clk);
        #1;
        e = sb0.pop_front();
        o = {a_x, a_y, a_b, a_h, a_v, a_sof, a_bd, a_hd, a_vd};
        check("dflt_cycle", 64'(o), 64'(e));
        e = sb1.pop_front();
        o = {s_x, s_y, s_b, s_h, s_v, s_sof, s_bd, s_hd, s_vd};
        check("small_cycle", 64'(o), 64'(e));
    endtask

    initial begin
        int cnt;
        int cnt2;
        int cnt3;
        int xf;
        int xd;
        int xb;

        // Reset, then one full line: column wraps and row steps exactly at 799 -> 0.
        step(1'b0, 1'b1);
        check("rst_x", 64'(a_x), 64'd0);
        check("rst_flags", 64'({a_b, a_h, a_v, a_sof}), 64'hF);
        check("rst_pipe", 64'({a_bd, a_hd, a_vd}), 64'h3);
        repeat (799) step(1'b1, 1'b1);
        check("last_col", 64'({a_x, a_y}), 64'({10'd799, 10'd0}));
        step(1'b1, 1'b1);
        check("wrap_line", 64'({a_x, a_y}), 64'({10'd0, 10'd1}));

        // Line 1: hs width, hs/hs_d fall positions, end of visible region.
        cnt = 0; xf = -1; xd = -1; xb = -1;
        repeat (800) begin
            step(1'b1, 1'b1);
            if (a_h == 1'b0) cnt++;
            if (a_h == 1'b0 && xf < 0) xf = a_x;
            if (a_hd == 1'b0 && xd < 0) xd = a_x;
            if (a_b == 1'b0 && xb < 0) xb = a_x;
        end
        check("hs_width", 64'(cnt), 64'd96);
        check("hs_fall_x", 64'(xf), 64'd656);
        check("hsd_fall_x", 64'(xd), 64'd658);
        check("blank_end_x", 64'(xb), 64'd640);

        // Small raster, one whole frame: vs span, visible area, single sof, hs_d lag of 3.
        step(1'b0, 1'b1);
        cnt = 0; cnt2 = 0; cnt3 = 0; xf = -1; xd = -1;
        for (int i = 1; i <= 192; i++) begin
            step(1'b1, 1'b1);
            if (s_v == 1'b0) cnt++;
            if (s_b == 1'b1) cnt2++;
            if (s_sof == 1'b1) cnt3++;
            if (s_h == 1'b0 && xf < 0) xf = i;
            if (s_hd == 1'b0 && xd < 0) xd = i;
        end
        check("vs_width_s", 64'(cnt), 64'd32);
        check("blank_cnt_s", 64'(cnt2), 64'd48);
        check("sof_cnt_s", 64'(cnt3), 64'd1);
        check("hsd_lag_s", 64'(xd - xf), 64'd3);

        // Alternating ce: half speed, holds on idle cycles, frame returns after 384 cycles.
        step(1'b0, 1'b1);
        cnt = 0;
        for (int i = 0; i < 384; i++) begin
            step(1'b1, (i % 2 == 0) ? 1'b1 : 1'b0);
            if (s_sof == 1'b1) cnt++;
        end
        check("half_rate_home_s", 64'({s_x, s_y, s_sof}), 64'({10'd0, 10'd0, 1'b1}));
        check("half_rate_sof_s", 64'(cnt), 64'd2);

        // Mid-line reset (reset wins over ce=0), then blank_d recovers after two advances.
        step(1'b0, 1'b1);
        repeat (1100) step(1'b1, 1'b1);
        check("pre_rst_pos", 64'({a_x, a_y}), 64'({10'd300, 10'd1}));
        step(1'b0, 1'b0);
        check("mid_rst", 64'({a_x, a_y, a_b, a_h, a_v, a_sof}), 64'({10'd0, 10'd0, 4'hF}));
        check("mid_rst_bd0", 64'(a_bd), 64'd0);
        step(1'b1, 1'b1);
        check("mid_rst_bd1", 64'(a_bd), 64'd0);
        step(1'b1, 1'b1);
        check("mid_rst_bd2", 64'(a_bd), 64'd1);
        step(1'b1, 1'b0);
        check("hold_bd", 64'({a_x, a_bd}), 64'({10'd2, 1'b1}));

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
